// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file debug dump path and the debug UART framer.
package regfile_dump_pkg;

  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned REG_DATA_W    = 32;
  localparam int unsigned NUM_ARCH_REGS = 32;

  // Dump FSM encoding, shared with the framer so both sides decode the same states.
  typedef logic [1:0] dump_state_t;
  localparam dump_state_t ST_IDLE = 2'd0;
  localparam dump_state_t ST_READ = 2'd1;
  localparam dump_state_t ST_SEND = 2'd2;
  localparam dump_state_t ST_DONE = 2'd3;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] id;
    logic [REG_DATA_W-1:0] data;
    logic                  last;
  } dump_word_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks the register file debug port and streams {index, data} words over valid/ready.
// Read-only observer: one holding stage, no skid buffer, no atomic snapshot.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS  = NUM_ARCH_REGS,
  parameter int unsigned ADDR_W    = REG_ADDR_W,
  parameter int unsigned DATA_W    = REG_DATA_W,
  parameter int unsigned SKIP_ZERO = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] reg_out_id,
  input  logic [DATA_W-1:0] reg_out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_id,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(SKIP_ZERO != 0 ? 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  dump_state_t state;
  dump_state_t state_nxt;
  logic        accept;
  logic        load_first;
  logic        capture;
  logic        advance;
  logic        drop_valid;

  assign accept = out_valid & out_ready;

  // Next state and datapath enables; abort takes priority over acceptance.
  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    drop_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_READ;
          load_first = 1'b1;
        end
      end
      ST_READ: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_SEND;
          capture   = 1'b1;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_nxt  = ST_IDLE;
          drop_valid = 1'b1;
        end else if (accept) begin
          drop_valid = 1'b1;
          if (out_last) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_READ;
            advance   = 1'b1;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // reg_out_id doubles as the walk index, so it holds its last value outside READ.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_out_id <= '0;
      out_valid  <= 1'b0;
      out_id     <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      done <= (state_nxt == ST_DONE);
      if (load_first) begin
        reg_out_id <= FIRST_IDX;
      end else if (advance) begin
        reg_out_id <= reg_out_id + ADDR_W'(1);
      end
      if (capture) begin
        out_valid <= 1'b1;
        out_id    <= reg_out_id;
        out_data  <= reg_out_data;
        out_last  <= (reg_out_id == LAST_IDX);
      end else if (drop_valid) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: expected words queued at start, popped on each handshake.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  localparam int unsigned N  = NUM_ARCH_REGS;
  localparam int unsigned AW = REG_ADDR_W;
  localparam int unsigned DW = REG_DATA_W;

  typedef struct {
    logic [AW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start0, abort0, rdy0, v0, ol0, busy0, done0;
  logic [AW-1:0] rid0, oid0;
  logic [DW-1:0] rdata0, od0;
  logic          start1, v1, ol1, busy1, done1;
  logic          abort1 = 1'b0;
  logic          rdy1   = 1'b1;
  logic [AW-1:0] rid1, oid1;
  logic [DW-1:0] rdata1, od1;

  logic [DW-1:0] regs [N];
  word_t         q0[$];
  word_t         q1[$];
  word_t         mw0, mw1, hw0;
  bit            held0 = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            exp_first0 = 0, exp_done0 = 0, exp_first1 = 0, exp_done1 = 0;
  int            done_cnt0 = 0, done_cnt1 = 0;
  bit            rmode, stall_en, hold_low;
  int            stall_cnt;
  bit            ok;

  assign rdata0 = regs[rid0];
  assign rdata1 = regs[rid1];

  regfile_dump #(.SKIP_ZERO(0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .abort(abort0),
    .reg_out_id(rid0), .reg_out_data(rdata0), .out_valid(v0), .out_ready(rdy0),
    .out_id(oid0), .out_data(od0), .out_last(ol0), .busy(busy0), .done(done0)
  );

  regfile_dump #(.SKIP_ZERO(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .abort(abort1),
    .reg_out_id(rid1), .reg_out_data(rdata1), .out_valid(v1), .out_ready(rdy1),
    .out_id(oid1), .out_data(od1), .out_last(ol1), .busy(busy1), .done(done1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: a dump is every index from the first one up to N-1, in order, with current contents.
  task automatic push_dump(input int which);
    word_t w;
    for (int i = (which == 1) ? 1 : 0; i < int'(N); i++) begin
      w.id   = AW'(i);
      w.data = regs[i];
      w.last = (i == int'(N) - 1);
      if (which == 0) q0.push_back(w);
      else            q1.push_back(w);
    end
  endtask

  // extra < 0: ready pattern is random, so the done cycle is not predicted.
  task automatic start_dump(input bit d0, input bit d1, input int extra);
    @(posedge clock); #2;
    if (d0) begin
      push_dump(0);
      exp_first0 = cyc + 2;
      exp_done0  = (extra >= 0) ? cyc + 2 * int'(N) + 1 + extra : 0;
    end
    if (d1) begin
      push_dump(1);
      exp_first1 = cyc + 2;
      exp_done1  = cyc + 2 * (int'(N) - 1) + 1;
    end
    start0 = d0;
    start1 = d1;
    @(posedge clock); #2;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < budget && !idle; k++) begin
      @(posedge clock); #2;
      idle = !busy0 && !busy1;
    end
    if (!idle) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_word(input logic [AW-1:0] id, output bit found);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(posedge clock); #2;
      found = v0 && (oid0 == id);
    end
    if (!found) chk("word_timeout", 64'd0, 64'(id));
  endtask

  // Sink ready for instance 0.
  always @(posedge clock) begin
    #1;
    if (hold_low) begin
      rdy0 = 1'b0;
    end else if (stall_en && v0 && oid0 == AW'(7) && stall_cnt < 5) begin
      rdy0 = 1'b0;
      stall_cnt++;
    end else if (rmode) begin
      rdy0 = 1'($urandom_range(0, 1));
    end else begin
      rdy0 = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      held0 = 1'b0;
    end else begin
      if (v0) begin
        if (held0) chk("hold_stable", {oid0, od0, ol0}, {hw0.id, hw0.data, hw0.last});
        if (exp_first0 != 0) begin
          chk("first_valid_cycle0", cyc, exp_first0);
          exp_first0 = 0;
        end
        if (rdy0) begin
          if (q0.size() == 0) begin
            chk("unexpected_word0", 64'(oid0), 64'hFFFF);
          end else begin
            mw0 = q0.pop_front();
            chk("word_id0", oid0, mw0.id);
            chk("word_data0", od0, mw0.data);
            chk("word_last0", ol0, mw0.last);
          end
        end
        held0  = !rdy0;
        hw0.id = oid0; hw0.data = od0; hw0.last = ol0;
      end else begin
        held0 = 1'b0;
      end
      if (done0) begin
        done_cnt0++;
        if (exp_done0 != 0) chk("done_cycle0", cyc, exp_done0);
        exp_done0 = 0;
        chk("done_queue_empty0", q0.size(), 0);
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      if (v1) begin
        if (exp_first1 != 0) begin
          chk("first_valid_cycle1", cyc, exp_first1);
          exp_first1 = 0;
        end
        if (q1.size() == 0) begin
          chk("unexpected_word1", 64'(oid1), 64'hFFFF);
        end else begin
          mw1 = q1.pop_front();
          chk("word_id1", oid1, mw1.id);
          chk("word_data1", od1, mw1.data);
          chk("word_last1", ol1, mw1.last);
        end
      end
      if (done1) begin
        done_cnt1++;
        if (exp_done1 != 0) chk("done_cycle1", cyc, exp_done1);
        exp_done1 = 0;
        chk("done_queue_empty1", q1.size(), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0;
    rmode = 1'b0; stall_en = 1'b0; hold_low = 1'b0; stall_cnt = 0;
    for (int i = 0; i < int'(N); i++) regs[i] = DW'(i) * 32'h0101_0101;

    #1 reset = 1'b0;
    #1;
    chk("reset_outputs0", {rid0, v0, oid0, od0, ol0, busy0, done0}, 64'd0);
    chk("reset_outputs1", {rid1, v1, oid1, od1, ol1, busy1, done1}, 64'd0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);

    // Full dump on both instances with ready held high.
    start_dump(1'b1, 1'b1, 0);
    wait_idle(400);
    chk("done_count0_a", done_cnt0, 1);
    chk("done_count1_a", done_cnt1, 1);
    chk("rid_hold0", rid0, N - 1);
    chk("rid_hold1", rid1, N - 1);
    chk("idle_valid0", v0, 0);

    // Five-cycle back-pressure on word 7.
    stall_en = 1'b1; stall_cnt = 0;
    start_dump(1'b1, 1'b0, 5);
    wait_idle(400);
    stall_en = 1'b0;
    chk("stall_cycles", stall_cnt, 5);
    chk("done_count0_b", done_cnt0, 2);

    // Second start mid-dump must be ignored.
    start_dump(1'b1, 1'b0, 0);
    wait_word(AW'(10), ok);
    start0 = 1'b1;
    @(posedge clock); #2;
    start0 = 1'b0;
    wait_idle(400);
    chk("done_count0_c", done_cnt0, 3);

    // Abort while word 12 is presented and held.
    start_dump(1'b1, 1'b0, -1);
    wait_word(AW'(11), ok);
    hold_low = 1'b1;
    wait_word(AW'(12), ok);
    abort0 = 1'b1;
    @(posedge clock); #2;
    abort0 = 1'b0;
    chk("abort_valid", v0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    q0.delete();
    hold_low = 1'b0;
    repeat (4) @(posedge clock);
    #2 chk("abort_no_done", done_cnt0, 3);
    start_dump(1'b1, 1'b0, 0);
    wait_idle(400);
    chk("done_count0_d", done_cnt0, 4);

    // Reset during word 20.
    start_dump(1'b1, 1'b0, -1);
    wait_word(AW'(20), ok);
    reset = 1'b0;
    #1;
    chk("midreset_outputs0", {rid0, v0, oid0, od0, ol0, busy0, done0}, 64'd0);
    chk("midreset_rid1", rid1, 0);
    q0.delete();
    exp_first0 = 0; exp_done0 = 0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    repeat (5) @(posedge clock);
    #2;
    chk("post_reset_idle", {busy0, v0, done0}, 0);

    // Random register contents and random sink back-pressure.
    rmode = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'(N); i++) regs[i] = $urandom;
      start_dump(1'b1, 1'b1, -1);
      wait_idle(1200);
      chk("rand_queue0", q0.size(), 0);
      chk("rand_queue1", q1.size(), 0);
    end
    chk("done_count0_e", done_cnt0, 7);
    chk("done_count1_e", done_cnt1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
